// File: rtl/downcount_monitor.sv
// Self-checking consumer for a down-counter: verifies each accepted sample is
// the previous one minus one (mod 2^WIDTH), flags wraps and keeps saturating tallies.
module downcount_monitor #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] q_in,
   input  logic             valid,
   input  logic             clr,
   output logic             wrap_pulse,
   output logic [CNT_W-1:0] wrap_count,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       state,
   output logic [WIDTH-1:0] last_q
);

   typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, ERROR = 2'd2} st_t;

   localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] Q_MAX = '1;
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_MAX = '1;

   st_t              state_q, state_d;
   logic [WIDTH-1:0] last_d;
   logic [CNT_W-1:0] wc_d, ec_d;
   logic             wp_d, err_d;
   logic [WIDTH-1:0] exp_q;
   logic             match, is_wrap;

   assign exp_q   = last_q - Q_ONE;
   assign match   = (q_in == exp_q);
   assign is_wrap = match && (last_q == '0) && (q_in == Q_MAX);
   assign state   = state_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      wc_d    = wrap_count;
      ec_d    = err_count;
      err_d   = err;
      wp_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // First sample only establishes the reference value.
            if (valid) begin
               last_d  = q_in;
               state_d = TRACK;
            end
         end
         TRACK, ERROR: begin
            if (valid) begin
               last_d = q_in;
               if (match) begin
                  state_d = TRACK;
                  if (is_wrap) begin
                     wp_d = 1'b1;
                     if (wrap_count != C_MAX) wc_d = wrap_count + C_ONE;
                  end
               end else begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  if (err_count != C_MAX) ec_d = err_count + C_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         state_q    <= IDLE;
         last_q     <= '0;
         wrap_count <= '0;
         err_count  <= '0;
         err        <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         wrap_count <= wc_d;
         err_count  <= ec_d;
         err        <= err_d;
         wrap_pulse <= wp_d;
      end
   end

endmodule

// File: doc/downcount_monitor.md
# downcount_monitor

Checker and statistics stage that sits directly downstream of the 4-bit down-counter. It samples the counter output, confirms every advance is a decrement by exactly one modulo 2^WIDTH, and emits a one-cycle pulse on each wrap from 0 to max. It keeps saturating wrap and error tallies and raises a sticky error flag, giving the counter a self-checking consumer both in simulation and on hardware.

## Interface
- WIDTH, 4, width of the monitored count.
- CNT_W, 8, width of the wrap_count and err_count tallies.
- clk  input  1  rising-edge clock; all state updates on this edge only.
- reset  input  1  synchronous, active-low reset; sampled on clk; low forces the reset state.
- q_in  input  WIDTH  count value from the down-counter.
- valid  input  1  high when q_in holds a new count sample this cycle; low means ignore q_in.
- clr  input  1  synchronous, active-high statistics clear.
- wrap_pulse  output  1  one-cycle pulse per detected 0 to max transition.
- wrap_count  output  CNT_W  number of wraps seen, saturating.
- err  output  1  sticky; set on the first sequence violation.
- err_count  output  CNT_W  number of violating samples, saturating.
- state  output  2  FSM state: IDLE=0, TRACK=1, ERROR=2; 3 is unused.
- last_q  output  WIDTH  most recently accepted sample.

## Operation
- Priority per edge: reset low > clr high > valid high > hold.
- Reset (reset=0): state=IDLE, last_q=0, wrap_count=0, err_count=0, err=0, wrap_pulse=0.
- clr=1 with reset high: same effect as reset. A sample presented in the same cycle is discarded.
- Expected value: exp = (last_q - 1) mod 2^WIDTH, so 0 is followed by 2^WIDTH-1.
- IDLE: the first valid sample is loaded into last_q with no check, then state goes to TRACK. No pulse is generated and no tally changes.
- TRACK, valid sample equal to exp:
  - last_q := q_in.
  - If last_q==0 and q_in==2^WIDTH-1, assert wrap_pulse and increment wrap_count.
- TRACK, valid sample not equal to exp:
  - last_q := q_in, which resynchronises the checker to the new value.
  - err := 1, err_count increments, state goes to ERROR.
  - A wrap is not counted, even if q_in==2^WIDTH-1.
- ERROR: the next valid sample uses the same check.
  - Match: state goes to TRACK. A wrap pulse and wrap count apply as in TRACK.
  - Mismatch: err_count increments again and state stays in ERROR.
- err stays at 1 through ERROR and TRACK until clr or reset.
- A repeated value (q_in == last_q) with valid=1 is a violation.
- valid=0: no state change, no check, wrap_pulse=0. q_in is don't-care.
- Saturation: wrap_count and err_count hold at 2^CNT_W-1 and never roll over.
- Arithmetic is unsigned. Decrement and comparison are done at WIDTH bits.
- Illegal state encoding 3 recovers to IDLE on the next edge.

## Timing
- All outputs are registered. The response to a sample valid at edge N is visible after edge N.
- Latency is 1 cycle:
  - wrap_pulse is high for exactly the one cycle following the edge that accepted the wrapping sample.
  - err, err_count and state update in that same cycle.
- Back-to-back valid samples every cycle are supported with no bubbles. Each cycle is checked independently.
- Releasing reset takes effect at the first edge with reset=1. The first valid sample at or after that edge is the IDLE reference.
- Reset or clr asserted mid-sequence:
  - Any pending tally update from that cycle's sample is dropped.
  - wrap_pulse is 0 in the following cycle.

## Test plan
- Reset: hold reset=0 for 3 edges while valid=1 and q_in=7 → every output is 0 and state=0; after release, the first valid sample q_in=7 gives state=1 and last_q=7.
- Normal wrap: valid=1 with sequence 3,2,1,0,15,14 → wrap_pulse is high only in the cycle after 15 is accepted, wrap_count=1, err=0, last_q=14.
- Violation and recovery: sequence 9,8,6,5 →
  - after 6: err=1, err_count=1, state=2;
  - after 5: state=1, err still 1, err_count still 1.
- Gaps and repeats: 4, then valid=0 for 3 cycles with q_in=0, then 3 → no error. Then 3 again with valid=1 → err_count=1.
- Saturation: drive 300 full 15..0 cycles plus a final 15 → wrap_count=255 and holds. Inject 260 mismatches → err_count=255.
- clr/reset collision: clr=1 with valid=1 and q_in=15 right after 0 → no wrap_pulse, counters 0, state=0. Repeat using reset=0 instead of clr → identical result.
